// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matmul memory/sequencing shell.
package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  localparam int unsigned READ_LAT    = 2;
  localparam int unsigned DefDwidth   = 16;
  localparam int unsigned DefMatSize  = 32;
  localparam int unsigned DefAwidth   = 7;

endpackage

// File: rtl/matmul_row_ram.sv
// Single-port synchronous row RAM, one row per address, registered 1-cycle read (read-first).
module matmul_row_ram #(
  parameter int unsigned RW     = 512,
  parameter int unsigned AWIDTH = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [RW-1:0]     wdata_i,
  output logic [RW-1:0]     rdata_o
);

  logic [RW-1:0] mem_q [2**AWIDTH];
  logic [RW-1:0] rdata_q;

  // Contents are deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/matmul_mem_sequencer.sv
// Memory/sequencing shell around a systolic matmul core: A/B/C row RAMs, run control, C drain.
// Optional RUN cycle counter enabled by defining MATMUL_SEQ_PERF_CNT_EN.
module matmul_mem_sequencer
  import matmul_pkg::*;
#(
  parameter int unsigned DWIDTH   = DefDwidth,
  parameter int unsigned MAT_SIZE = DefMatSize,
  parameter int unsigned AWIDTH   = DefAwidth
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       host_wr_valid,
  output logic                       host_wr_ready,
  input  logic                       host_wr_sel,
  input  logic [AWIDTH-1:0]          host_wr_addr,
  input  logic [MAT_SIZE*DWIDTH-1:0] host_wr_data,
  input  logic                       cmd_start,
  output logic                       busy,
  output logic                       done_pulse,
  output logic                       err_overflow,
  output logic                       core_start,
  input  logic                       core_done,
  input  logic [AWIDTH-1:0]          core_a_addr,
  input  logic [AWIDTH-1:0]          core_b_addr,
  output logic [MAT_SIZE*DWIDTH-1:0] core_a_data,
  output logic [MAT_SIZE*DWIDTH-1:0] core_b_data,
  input  logic                       core_c_valid,
  input  logic [MAT_SIZE*DWIDTH-1:0] core_c_data,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [MAT_SIZE*DWIDTH-1:0] res_data,
  output logic                       res_last,
  output logic [31:0]                perf_cycles
);

  localparam int unsigned RW = MAT_SIZE * DWIDTH;
  localparam logic [AWIDTH:0] RowsN   = (AWIDTH+1)'(MAT_SIZE);
  localparam logic [AWIDTH:0] RowLast = (AWIDTH+1)'(MAT_SIZE - 1);
  localparam logic [AWIDTH:0] PtrOne  = {{AWIDTH{1'b0}}, 1'b1};

  seq_state_t        state_q, state_d;
  logic [AWIDTH-1:0] a_addr_q, b_addr_q;
  logic [AWIDTH:0]   c_wr_ptr_q, rd_ptr_q;
  logic              err_q, done_q, inflight_q, inflight_last_q;
  logic [RW-1:0]     fifo_data_q [2];
  logic [1:0]        fifo_last_q;
  logic              fifo_wr_q, fifo_rd_q;
  logic [1:0]        fifo_cnt_q;

  logic              in_idle, in_run, in_drain, run_entry;
  logic              a_we, b_we, c_we, pop, push, issue, last_hs;
  logic [AWIDTH-1:0] a_ram_addr, b_ram_addr, c_ram_addr;
  logic [RW-1:0]     c_rdata;
  logic [2:0]        occ;

  always_comb begin
    in_idle    = (state_q == IDLE);
    in_run     = (state_q == RUN);
    in_drain   = (state_q == DRAIN);
    run_entry  = in_idle & cmd_start;
    a_we       = in_idle & host_wr_valid & ~host_wr_sel;
    b_we       = in_idle & host_wr_valid & host_wr_sel;
    a_ram_addr = a_we ? host_wr_addr : a_addr_q;
    b_ram_addr = b_we ? host_wr_addr : b_addr_q;
    c_we       = in_run & core_c_valid & (c_wr_ptr_q < RowsN);
    // C port writes during RUN, reads the drain pointer otherwise.
    c_ram_addr = in_run ? c_wr_ptr_q[AWIDTH-1:0] : rd_ptr_q[AWIDTH-1:0];
    res_valid  = (fifo_cnt_q != 2'd0);
    res_data   = res_valid ? fifo_data_q[fifo_rd_q] : '0;
    res_last   = res_valid & fifo_last_q[fifo_rd_q];
    pop        = res_valid & res_ready;
    push       = inflight_q;
    last_hs    = pop & res_last;
    // Only issue a read if the skid buffer has room once this cycle's pop is accounted for.
    occ        = {1'b0, fifo_cnt_q} + {2'b00, inflight_q};
    issue      = in_drain & (rd_ptr_q < RowsN) & (occ < (3'd2 + {2'b00, pop}));
    busy          = ~in_idle;
    core_start    = in_run;
    host_wr_ready = in_idle;
    done_pulse    = done_q;
    err_overflow  = err_q;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_start) state_d = RUN;
      RUN:     if (core_done) state_d = DRAIN;
      DRAIN:   if (last_hs)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      a_addr_q        <= '0;
      b_addr_q        <= '0;
      c_wr_ptr_q      <= '0;
      rd_ptr_q        <= '0;
      err_q           <= 1'b0;
      done_q          <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      fifo_last_q     <= '0;
      fifo_wr_q       <= 1'b0;
      fifo_rd_q       <= 1'b0;
      fifo_cnt_q      <= '0;
    end else begin
      state_q  <= state_d;
      a_addr_q <= core_a_addr;
      b_addr_q <= core_b_addr;
      if (run_entry) begin
        c_wr_ptr_q <= '0;
      end else if (c_we) begin
        c_wr_ptr_q <= c_wr_ptr_q + PtrOne;
      end
      if (run_entry) begin
        err_q <= 1'b0;
      end else if (in_run && core_c_valid && (c_wr_ptr_q == RowsN)) begin
        err_q <= 1'b1;
      end
      if (!in_drain) begin
        rd_ptr_q <= '0;
      end else if (issue) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
      end
      inflight_q      <= issue;
      inflight_last_q <= (rd_ptr_q == RowLast);
      if (push) begin
        fifo_last_q[fifo_wr_q] <= inflight_last_q;
        fifo_wr_q              <= ~fifo_wr_q;
      end
      if (pop) begin
        fifo_rd_q <= ~fifo_rd_q;
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, push} - {1'b0, pop};
      done_q     <= last_hs;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[fifo_wr_q] <= c_rdata;
    end
  end

`ifdef MATMUL_SEQ_PERF_CNT_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk) begin
    if (reset || run_entry) begin
      perf_q <= '0;
    end else if (in_run && (perf_q != '1)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

  matmul_row_ram #(.RW(RW), .AWIDTH(AWIDTH)) u_ram_a (
    .clk     (clk),
    .reset   (reset),
    .we_i    (a_we),
    .addr_i  (a_ram_addr),
    .wdata_i (host_wr_data),
    .rdata_o (core_a_data)
  );

  matmul_row_ram #(.RW(RW), .AWIDTH(AWIDTH)) u_ram_b (
    .clk     (clk),
    .reset   (reset),
    .we_i    (b_we),
    .addr_i  (b_ram_addr),
    .wdata_i (host_wr_data),
    .rdata_o (core_b_data)
  );

  matmul_row_ram #(.RW(RW), .AWIDTH(AWIDTH)) u_ram_c (
    .clk     (clk),
    .reset   (reset),
    .we_i    (c_we),
    .addr_i  (c_ram_addr),
    .wdata_i (core_c_data),
    .rdata_o (c_rdata)
  );

endmodule

// File: tb/tb_matmul_mem_sequencer.sv
// Directed/randomised bench for matmul_mem_sequencer with a behavioural core and matmul reference.
module tb_matmul_mem_sequencer;

  localparam int DW  = 16;
  localparam int MS  = 32;
  localparam int AW  = 7;
  localparam int RW  = MS * DW;
  localparam int NRD = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic          host_wr_valid, host_wr_ready, host_wr_sel;
  logic [AW-1:0] host_wr_addr;
  logic [RW-1:0] host_wr_data;
  logic          cmd_start, busy, done_pulse, err_overflow, core_start, core_done;
  logic [AW-1:0] core_a_addr, core_b_addr;
  logic [RW-1:0] core_a_data, core_b_data;
  logic          core_c_valid;
  logic [RW-1:0] core_c_data;
  logic          res_valid, res_ready, res_last;
  logic [RW-1:0] res_data;
  logic [31:0]   perf_cycles;

  always #5 clk = ~clk;

  matmul_mem_sequencer #(.DWIDTH(DW), .MAT_SIZE(MS), .AWIDTH(AW)) dut (
    .clk           (clk),
    .reset         (reset),
    .host_wr_valid (host_wr_valid),
    .host_wr_ready (host_wr_ready),
    .host_wr_sel   (host_wr_sel),
    .host_wr_addr  (host_wr_addr),
    .host_wr_data  (host_wr_data),
    .cmd_start     (cmd_start),
    .busy          (busy),
    .done_pulse    (done_pulse),
    .err_overflow  (err_overflow),
    .core_start    (core_start),
    .core_done     (core_done),
    .core_a_addr   (core_a_addr),
    .core_b_addr   (core_b_addr),
    .core_a_data   (core_a_data),
    .core_b_data   (core_b_data),
    .core_c_valid  (core_c_valid),
    .core_c_data   (core_c_data),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_data      (res_data),
    .res_last      (res_last),
    .perf_cycles   (perf_cycles)
  );

  int checks = 0;
  int errors = 0;
  logic [RW-1:0] a_sh [128];
  logic [RW-1:0] b_sh [128];
  logic [RW-1:0] c_exp [MS];
  int rd_list [NRD] = '{0, 1, 3, 31, 40, 17};

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] rnd_row();
    logic [RW-1:0] r;
    for (int w = 0; w < RW / 32; w++) r[w*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference: C = A x B over rows 0..MS-1, elements modulo 2**DW.
  function automatic void compute_c();
    for (int i = 0; i < MS; i++) begin
      for (int j = 0; j < MS; j++) begin
        logic [DW-1:0] s;
        s = '0;
        for (int k = 0; k < MS; k++) s = s + a_sh[i][k*DW +: DW] * b_sh[k][j*DW +: DW];
        c_exp[i][j*DW +: DW] = s;
      end
    end
  endfunction

  task automatic host_write(input logic sel, input int addr, input logic [RW-1:0] data);
    host_wr_valid = 1'b1;
    host_wr_sel   = sel;
    host_wr_addr  = AW'(addr);
    host_wr_data  = data;
    tick();
    host_wr_valid = 1'b0;
    if (sel) b_sh[addr] = data;
    else a_sh[addr] = data;
  endtask

  // Optionally performs a B-row host write in the same cycle as cmd_start.
  task automatic start_run(input bit with_wr, input int addr, input logic [RW-1:0] data);
    cmd_start = 1'b1;
    if (with_wr) begin
      host_wr_valid = 1'b1;
      host_wr_sel   = 1'b1;
      host_wr_addr  = AW'(addr);
      host_wr_data  = data;
      b_sh[addr]    = data;
    end
    compute_c();
    tick();
    cmd_start     = 1'b0;
    host_wr_valid = 1'b0;
    chk1("run_entry_core_start", core_start, 1'b1);
    chk1("run_entry_err_clear", err_overflow, 1'b0);
  endtask

  // Behavioural core: reads A/B rows, emits C rows, raises core_done; ends in first DRAIN cycle.
  task automatic run_core(input int n_rows, input int min_run, input bit hw_in_run);
    int rc = 1;
    int run_len = 0;
    int exp_perf;
    bit done_sent = 1'b0;
    if (hw_in_run) begin
      chk1("wr_ready_in_run", host_wr_ready, 1'b0);
      host_wr_valid = 1'b1;
      host_wr_sel   = 1'b0;
      host_wr_addr  = AW'(3);
      host_wr_data  = rnd_row();
      tick(); rc++;
      host_wr_valid = 1'b0;
    end
    for (int i = 0; i < NRD + 2; i++) begin
      if (i < NRD) begin
        core_a_addr = AW'(rd_list[i]);
        core_b_addr = AW'(rd_list[NRD-1-i]);
      end
      if (i >= 2) begin
        chkw("a_read", core_a_data, a_sh[rd_list[i-2]]);
        chkw("b_read", core_b_data, b_sh[rd_list[NRD+1-i]]);
      end
      tick(); rc++;
    end
    for (int r = 0; r < n_rows; r++) begin
      repeat ($urandom_range(0, 1)) begin
        tick(); rc++;
      end
      core_c_valid = 1'b1;
      core_c_data  = (r < MS) ? c_exp[r] : rnd_row();
      if (r == n_rows - 1 && rc >= min_run) begin
        core_done = 1'b1;
        done_sent = 1'b1;
        run_len   = rc;
      end
      tick(); rc++;
      core_c_valid = 1'b0;
      core_done    = 1'b0;
    end
    if (!done_sent) begin
      while (rc < min_run) begin
        tick(); rc++;
      end
      core_done = 1'b1;
      run_len   = rc;
      tick();
      core_done = 1'b0;
    end
`ifdef MATMUL_SEQ_PERF_CNT_EN
    exp_perf = run_len;
`else
    exp_perf = 0;
`endif
    chk1("drain_core_start", core_start, 1'b0);
    chk1("drain_busy", busy, 1'b1);
    chk1("err_overflow", err_overflow, n_rows > MS);
    chk32("perf_cycles", perf_cycles, exp_perf);
  endtask

  function automatic logic ready_of(input int pattern, input int c);
    if (pattern == 0) return 1'b1;
    if (pattern == 1) return (c < 20) ? (c % 2 == 0) : (c >= 30);
    return 1'($urandom_range(0, 1));
  endfunction

  // Consumes result rows from the first DRAIN cycle; stops after max_rows handshakes.
  task automatic drain(input int pattern, input int max_rows, input bit cmd_in_drain);
    int idx = 0, c = 0, bubbles = 0, dp_seen = 0, first_hs = -1, last_hs = -1;
    int hi_from;
    bit stall = 1'b0;
    logic [RW-1:0] pd;
    logic pl;
    hi_from = (pattern == 0) ? 2 : (pattern == 1) ? 30 : 100000;
    while (idx < max_rows && c < 400) begin
      res_ready = ready_of(pattern, c);
      cmd_start = cmd_in_drain && (c == 5);
      if (stall) begin
        chk1("stall_valid", res_valid, 1'b1);
        chkw("stall_data", res_data, pd);
        chk1("stall_last", res_last, pl);
      end
      if (res_valid && res_ready) begin
        chkw("res_row", res_data, c_exp[idx]);
        chk1("res_last", res_last, idx == MS - 1);
        if (first_hs < 0) first_hs = c;
        last_hs = c;
        idx++;
      end else if (res_ready && !res_valid && c >= hi_from) begin
        bubbles++;
      end
      if (done_pulse) dp_seen++;
      stall = res_valid && !res_ready;
      pd    = res_data;
      pl    = res_last;
      tick(); c++;
    end
    res_ready = 1'b0;
    cmd_start = 1'b0;
    chk32("drain_rows", idx, max_rows);
    chk32("done_early", dp_seen, 0);
    if (max_rows == MS) begin
      chk1("done_pulse", done_pulse, 1'b1);
      chk1("idle_after_drain", busy, 1'b0);
      chk32("bubbles", bubbles, 0);
      if (pattern == 0) begin
        chk32("first_res_cycle", first_hs, 2);
        chk32("last_res_cycle", last_hs, MS + 1);
      end
      tick();
      chk1("done_pulse_once", done_pulse, 1'b0);
      chk1("still_idle", busy, 1'b0);
    end
  endtask

  initial begin
    logic [RW-1:0] row;
    reset = 1'b1; host_wr_valid = 1'b0; host_wr_sel = 1'b0; host_wr_addr = '0;
    host_wr_data = '0; cmd_start = 1'b0; core_done = 1'b0; core_a_addr = '0;
    core_b_addr = '0; core_c_valid = 1'b0; core_c_data = '0; res_ready = 1'b0;
    for (int i = 0; i < 128; i++) begin
      a_sh[i] = '0;
      b_sh[i] = '0;
    end
    tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_wr_ready", host_wr_ready, 1'b1);
    chk1("rst_core_start", core_start, 1'b0);
    chk1("rst_res_valid", res_valid, 1'b0);
    chk1("rst_done", done_pulse, 1'b0);
    chk1("rst_err", err_overflow, 1'b0);
    chk32("rst_perf", perf_cycles, 0);
    chkw("rst_res_data", res_data, '0);
    chkw("rst_a_data", core_a_data, '0);
    tick();
    reset = 1'b0;

    // A = identity, B row k = k everywhere; row 40 is outside the matrix but still addressable.
    for (int k = 0; k < MS; k++) begin
      row = '0;
      row[k*DW +: DW] = DW'(1);
      host_write(1'b0, k, row);
    end
    host_write(1'b0, 40, rnd_row());
    for (int k = 0; k < MS - 1; k++) begin
      for (int j = 0; j < MS; j++) row[j*DW +: DW] = DW'(k);
      host_write(1'b1, k, row);
    end
    for (int j = 0; j < MS; j++) row[j*DW +: DW] = DW'(MS - 1);
    host_write(1'b1, 40, rnd_row());
    start_run(1'b1, MS - 1, row);
    run_core(MS, 0, 1'b0);
    drain(0, MS, 1'b0);

    // Reset in the middle of a drain, then a full rerun.
    start_run(1'b0, 0, '0);
    run_core(MS, 0, 1'b0);
    drain(0, 5, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_res_valid", res_valid, 1'b0);
    chk1("abort_core_start", core_start, 1'b0);
    chk1("abort_done", done_pulse, 1'b0);
    tick();
    chk1("abort_done_later", done_pulse, 1'b0);
    start_run(1'b0, 0, '0);
    run_core(MS, 0, 1'b0);
    drain(0, MS, 1'b0);

    // Random matrices with a stalling consumer.
    for (int k = 0; k < MS; k++) host_write(1'b0, k, rnd_row());
    for (int k = 0; k < MS; k++) host_write(1'b1, k, rnd_row());
    start_run(1'b0, 0, '0);
    run_core(MS, 0, 1'b0);
    drain(1, MS, 1'b0);

    // Overflow: 33 C rows, then cmd_start clears the flag.
    start_run(1'b0, 0, '0);
    run_core(MS + 1, 0, 1'b0);
    drain(2, MS, 1'b0);
    chk1("err_sticky", err_overflow, 1'b1);
    start_run(1'b0, 0, '0);
    run_core(MS, 0, 1'b0);
    drain(2, MS, 1'b0);

    // Host write blocked in RUN; cmd_start ignored in DRAIN.
    start_run(1'b0, 0, '0);
    run_core(MS, 0, 1'b1);
    drain(0, MS, 1'b1);

    // Long RUN for the cycle counter.
    start_run(1'b0, 0, '0);
    run_core(MS, 100, 1'b0);
    drain(0, MS, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
